// File: rtl/serial_add_unit_if.sv
// Handshake and operand/result bundle for serial_add_unit.
// With SERIAL_ADD_SUB_EN defined, a sub request bit travels alongside the operands.
interface serial_add_unit_if #(
  parameter int WIDTH = 6
);
  // Handshake: start is a request that the unit samples only in IDLE or DONE,
  // and the operands are captured on that same edge. done is a one-cycle
  // pulse, and sum/overflow stay valid from done until the next result lands.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic [1:0]       state;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, overflow, state);
  modport slave  (input start, a, b, sub, output busy, done, sum, overflow, state);
`else
  modport master (output start, a, b, input busy, done, sum, overflow, state);
  modport slave  (input start, a, b, output busy, done, sum, overflow, state);
`endif
endinterface

// File: rtl/serial_add_unit.sv
// Bit-serial signed adder: one full-adder cell, LSB first, WIDTH cycles per result.
// Optional SERIAL_ADD_SUB_EN adds a sub input so the unit can compute a-b.
module serial_add_unit #(
  parameter int WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_add_unit_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] accept_b;
  logic             accept_cin;
  logic             fa_sum;
  logic             fa_cout;

  // Subtraction is a + ~b + 1: invert b on capture and seed the carry.
`ifdef SERIAL_ADD_SUB_EN
  assign accept_b   = bus.b ^ {WIDTH{bus.sub}};
  assign accept_cin = bus.sub;
`else
  assign accept_b   = bus.b;
  assign accept_cin = 1'b0;
`endif

  assign fa_sum  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_cout = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = accept_b;
          carry_d = accept_cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Published outputs move only here so they stay stable through the next run.
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          ovf_d   = carry_q ^ fa_cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.overflow = ovf_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_serial_add_unit.sv
// Directed-vector bench for serial_add_unit at WIDTH=6, plus exhaustive sweep,
// back-to-back start, and mid-run reset sequences.
module tb_serial_add_unit;
  localparam int W = 6;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_add_unit_if #(.WIDTH(W)) bus_if ();

  serial_add_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                sub;
    logic [W-1:0]        s;
    logic                o;
  } vec_t;

  vec_t       vecs[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_sub(input logic sv);
`ifdef SERIAL_ADD_SUB_EN
    bus_if.sub = sv;
`else
    if (sv) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
  endtask

  // Issues one operation and waits for done; operands are scrambled after acceptance.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        output logic [W-1:0] s, output logic o, output int lat, output int bc);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = av;
    bus_if.b     = bv;
    set_sub(sv);
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.a     = W'($urandom);
    bus_if.b     = W'($urandom);
    lat = 0;
    bc  = 0;
    while (!bus_if.done && lat < 40) begin
      if (bus_if.busy) bc++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    s = bus_if.sum;
    o = bus_if.overflow;
  endtask

  task automatic add_vec(input int av, input int bv, input logic sv, input int sv_exp, input logic ov);
    vec_t v;
    v.a   = W'(av);
    v.b   = W'(bv);
    v.sub = sv;
    v.s   = W'(sv_exp);
    v.o   = ov;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] s;
    logic         o;
    int           lat;
    int           bc;
    int           cyc;
    int           seen_done;
    logic [W-1:0] prev_sum;

    tests = 0;
    fails = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    set_sub(1'b0);

    add_vec(5, -3, 1'b0, 2, 1'b0);
    add_vec(31, 1, 1'b0, -32, 1'b1);
    add_vec(-32, -1, 1'b0, 31, 1'b1);
    add_vec(-32, 31, 1'b0, -1, 1'b0);
    add_vec(0, 0, 1'b0, 0, 1'b0);
    add_vec(-1, -1, 1'b0, -2, 1'b0);
    add_vec(-16, -16, 1'b0, -32, 1'b0);
    add_vec(16, 16, 1'b0, -32, 1'b1);
    add_vec(-17, -16, 1'b0, 31, 1'b1);
    add_vec(2, 2, 1'b0, 4, 1'b0);
`ifdef SERIAL_ADD_SUB_EN
    add_vec(-32, 1, 1'b1, 31, 1'b1);
    add_vec(3, 7, 1'b1, -4, 1'b0);
    add_vec(0, -32, 1'b1, -32, 1'b1);
    add_vec(5, -3, 1'b1, 8, 1'b0);
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus_if.busy), 0);
    check("rst_done", 32'(bus_if.done), 0);
    check("rst_sum", 32'(bus_if.sum), 0);
    check("rst_ovf", 32'(bus_if.overflow), 0);
    check("rst_state", 32'(bus_if.state), 0);
    rst_n = 1'b1;

    // Latency and busy width on the first transaction
    run_op(W'(5), W'(-3), 1'b0, s, o, lat, bc);
    check("lat_done_edge", 32'(lat), W);
    check("lat_busy_cycles", 32'(bc), W);
    check("lat_sum", 32'(s), 32'(W'(2)));
    @(negedge clk);
    check("done_one_cycle", 32'(bus_if.done), 0);
    check("idle_after_done", 32'(bus_if.state), 0);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, s, o, lat, bc);
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].s));
      check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].o));
    end

    // Exhaustive signed sweep against an integer model
    for (int ia = -32; ia < 32; ia++) begin
      for (int ib = -32; ib < 32; ib++) begin
        int tsum;
        logic [W-1:0] esum;
        tsum = ia + ib;
        esum = W'(tsum);
        run_op(W'(ia), W'(ib), 1'b0, s, o, lat, bc);
        check($sformatf("sweep_sum %0d+%0d", ia, ib), 32'(s), 32'(esum));
        check($sformatf("sweep_ovf %0d+%0d", ia, ib), 32'(o), (tsum > 31 || tsum < -32) ? 1 : 0);
      end
    end

    // Back-to-back with start held high; operands churn during RUN
    exp_q.push_back(W'(7));
    exp_q.push_back(W'(-20));
    exp_q.push_back(W'(-1));
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = W'(3);
    bus_if.b     = W'(4);
    prev_sum     = bus_if.sum;
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] e;
      e   = exp_q.pop_front();
      cyc = 0;
      do begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (!bus_if.done) begin
          bus_if.a = W'($urandom);
          bus_if.b = W'($urandom);
          if (cyc == 3) check($sformatf("b2b%0d_sum_stable", k), 32'(bus_if.sum), 32'(prev_sum));
          if (cyc == 1) check($sformatf("b2b%0d_busy", k), 32'(bus_if.busy), 1);
        end
      end while (!bus_if.done && cyc < 30);
      check($sformatf("b2b%0d_period", k), 32'(cyc), W + 1);
      check($sformatf("b2b%0d_sum", k), 32'(bus_if.sum), 32'(e));
      prev_sum = bus_if.sum;
      if (k == 0) begin bus_if.a = W'(-10); bus_if.b = W'(-10); end
      if (k == 1) begin bus_if.a = W'(-32); bus_if.b = W'(31); end
    end
    bus_if.start = 1'b0;
    @(negedge clk);
    check("b2b_end_idle", 32'(bus_if.state), 0);

    // Reset during RUN
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a     = W'(31);
    bus_if.b     = W'(1);
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus_if.busy), 0);
    check("midrst_sum", 32'(bus_if.sum), 0);
    check("midrst_ovf", 32'(bus_if.overflow), 0);
    check("midrst_state", 32'(bus_if.state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.done) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 0);
    run_op(W'(2), W'(2), 1'b0, s, o, lat, bc);
    check("postrst_sum", 32'(s), 4);
    check("postrst_ovf", 32'(o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
